aes_encrypt_seq: RTL

Iterative AES-128 encryption sequencer. Accepts a plaintext/key pair over a valid/ready handshake and performs the initial AddRoundKey. It then drives the shared round-function datapath for rounds 1–9 (one round per cycle) and applies a final round without MixColumns. The resulting ciphertext is presented over a second valid/ready handshake. It sits directly upstream of, and wraps, the rounds-1-to-9 round function, supplying its word, key and round-constant inputs and registering its outputs.

---
 rtl/aes_encrypt_seq_pkg.sv | 106 ++++++++++
 rtl/aes_encrypt_seq_final_round.sv | 19 +
 rtl/aes_round.sv | 19 +
 rtl/aes_encrypt_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/aes_encrypt_seq_pkg.sv
// Shared AES-128 definitions: FSM state encoding, round constants, S-box
// table and the byte-level transforms used by the round datapaths.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;
  localparam int         NUM_ROUNDS = 10;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8) with the AES polynomial; result stays 8 bits.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // SubBytes is byte-wise, so byte order inside the vector does not matter.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return r;
  endfunction

  // Byte b = row + 4*col sits at bits [127-8b -: 8]; row r rotates left by r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127 - 8*(row + 4*c) -: 8] = s[127 - 8*(row + 4*((c + row) % 4)) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      r[127 - 32*c -: 32] = mix_column(s[127 - 32*c -: 32]);
    end
    return r;
  endfunction

  // One step of the AES-128 key schedule: next round key from the current one.
  function automatic logic [127:0] key_expand(input logic [127:0] key, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    w0  = key[127:96];
    w1  = key[95:64];
    w2  = key[63:32];
    w3  = key[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rcon, 24'h000000};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_encrypt_seq_final_round.sv
// AES final round (round 10): SubBytes, ShiftRows, AddRoundKey, no MixColumns.
// Purely combinational; also yields the last round key.
module aes_final_round
  import aes_pkg::*;
(
  input  logic [127:0] i_word,
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_word,
  output logic [127:0] o_key
);

  logic [127:0] w_key_next;

  assign w_key_next = key_expand(i_key, i_rcon);
  assign o_word     = add_round_key(shift_rows(sub_bytes(i_word)), w_key_next);
  assign o_key      = w_key_next;

endmodule

// File: rtl/aes_round.sv
// AES round for rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
// Purely combinational; the sequencer registers the word and key outputs.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] i_word,
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_word,
  output logic [127:0] o_key
);

  logic [127:0] w_key_next;

  assign w_key_next = key_expand(i_key, i_rcon);
  assign o_word     = add_round_key(mix_columns(shift_rows(sub_bytes(i_word))), w_key_next);
  assign o_key      = w_key_next;

endmodule

// File: rtl/aes_encrypt_seq.sv
// Iterative AES-128 encryption sequencer: accepts plaintext/key, performs the
// initial AddRoundKey, runs rounds 1..9 through aes_round and round 10 through
// aes_final_round, one round per cycle, and presents the ciphertext over a
// valid/ready handshake.
// Optional feature macro: AES_LAST_KEY_OUT_EN adds the last_key output
// (round-10 key, for seeding a decryption key schedule).
module aes_encrypt_seq #(
  parameter int NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_text,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_text
`ifdef AES_LAST_KEY_OUT_EN
  ,
  output logic [127:0] last_key
`endif
);

  import aes_pkg::*;

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

  state_t       r_fsm;
  state_t       w_fsm_next;
  logic [127:0] r_state;
  logic [127:0] r_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_rnd;
  logic         r_in_ready;
  logic         r_out_valid;

  logic [127:0] w_round_word;
  logic [127:0] w_round_key;
  logic [127:0] w_final_word;
  logic [127:0] w_final_key;
  logic         w_last_rnd;

  assign w_last_rnd = (r_rnd == LAST_RND);

  aes_round u_round (
    .i_word (r_state),
    .i_key  (r_key),
    .i_rcon (r_rcon),
    .o_word (w_round_word),
    .o_key  (w_round_key)
  );

  aes_final_round u_final (
    .i_word (r_state),
    .i_key  (r_key),
    .i_rcon (r_rcon),
    .o_word (w_final_word),
    .o_key  (w_final_key)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // Next-state logic: accept in IDLE, count rounds, wait for the consumer in DONE.
  always_comb begin
    w_fsm_next = r_fsm;
    case (r_fsm)
      IDLE: begin
        if (in_valid) begin
          w_fsm_next = ROUND;
        end else begin
          w_fsm_next = IDLE;
        end
      end
      ROUND: begin
        if (w_last_rnd) begin
          w_fsm_next = DONE;
        end else begin
          w_fsm_next = ROUND;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_fsm_next = IDLE;
        end else begin
          w_fsm_next = DONE;
        end
      end
      default: begin
        w_fsm_next = IDLE;
      end
    endcase
  end

  // Handshake flags registered from the next state so neither depends
  // combinationally on the opposite side's valid/ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= (w_fsm_next == IDLE);
      r_out_valid <= (w_fsm_next == DONE);
    end
  end

  // Datapath: load on accept, one round per cycle, hold while waiting in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= 128'h0;
      r_key   <= 128'h0;
      r_rcon  <= RCON_INIT;
      r_rnd   <= 4'd0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (in_valid) begin
            r_state <= add_round_key(in_text, in_key);
            r_key   <= in_key;
            r_rcon  <= RCON_INIT;
            r_rnd   <= 4'd1;
          end
        end
        ROUND: begin
          r_rcon <= xtime(r_rcon);
          if (w_last_rnd) begin
            r_state <= w_final_word;
            r_key   <= w_final_key;
          end else begin
            r_state <= w_round_word;
            r_key   <= w_round_key;
            r_rnd   <= r_rnd + 4'd1;
          end
        end
        DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] r_last_key;

  // Capture the round-10 key on the final round edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_key <= 128'h0;
    end else if ((r_fsm == ROUND) && w_last_rnd) begin
      r_last_key <= w_final_key;
    end else begin
      r_last_key <= r_last_key;
    end
  end

  assign last_key = r_last_key;
`endif

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_text  = r_state;

endmodule
